// File: rtl/regfile.sv
// LEGv8 general-purpose register file: 31 writable 64-bit registers plus XZR,
// synchronous write with reset priority, two independent combinational read ports.
`timescale 1ps/1ps
module regfile #(
    parameter int WIDTH = 64,
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);

    localparam int NSTORE = NREGS - 1;

    logic [WIDTH-1:0] regs_reg [0:NSTORE-1];
    logic [NSTORE-1:0] write_en;
    logic [WIDTH-1:0] leaf [0:NREGS-1];
    logic [WIDTH-1:0] rd [0:1];

    // One-hot write decode; index 31 has no enable at all, so XZR writes vanish.
    generate
        for (genvar gi = 0; gi < NSTORE; gi++) begin : g_dec
            assign write_en[gi] = RegWrite && (WriteRegister == 5'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NSTORE; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSTORE; i++) begin
                if (write_en[i]) begin
                    regs_reg[i] <= WriteData;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_leaf
            if (gi == NREGS - 1) begin : g_zero
                assign leaf[gi] = '0;
            end else begin : g_reg
                assign leaf[gi] = regs_reg[gi];
            end
        end
    endgenerate

    // Per port: five levels of 2:1 muxes, select bit 0 at the leaves, bit 4 at the root.
    generate
        for (genvar gp = 0; gp < 2; gp++) begin : g_port
            logic [4:0]       sel;
            logic [WIDTH-1:0] lvl1 [0:15];
            logic [WIDTH-1:0] lvl2 [0:7];
            logic [WIDTH-1:0] lvl3 [0:3];
            logic [WIDTH-1:0] lvl4 [0:1];

            if (gp == 0) begin : g_sel1
                assign sel = ReadRegister1;
            end else begin : g_sel2
                assign sel = ReadRegister2;
            end

            for (genvar gi = 0; gi < 16; gi++) begin : g_l1
                assign lvl1[gi] = sel[0] ? leaf[2*gi+1] : leaf[2*gi];
            end
            for (genvar gi = 0; gi < 8; gi++) begin : g_l2
                assign lvl2[gi] = sel[1] ? lvl1[2*gi+1] : lvl1[2*gi];
            end
            for (genvar gi = 0; gi < 4; gi++) begin : g_l3
                assign lvl3[gi] = sel[2] ? lvl2[2*gi+1] : lvl2[2*gi];
            end
            for (genvar gi = 0; gi < 2; gi++) begin : g_l4
                assign lvl4[gi] = sel[3] ? lvl3[2*gi+1] : lvl3[2*gi];
            end
            assign rd[gp] = sel[4] ? lvl4[1] : lvl4[0];
        end
    endgenerate

    assign ReadData1 = rd[0];
    assign ReadData2 = rd[1];

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: reset, full write/read sweep, XZR, write-enable,
// same-cycle read/write ordering and reset-over-write priority.
`timescale 1ps/1ps
module tb_regfile;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    int checks = 0;
    int errors = 0;
    logic [63:0] base = 64'h0123_4567_89AB_CD00;

    regfile #(.WIDTH(64), .NREGS(32)) dut (
        .clk(clk),
        .reset(reset),
        .RegWrite(RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData(WriteData),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .ReadData1(ReadData1),
        .ReadData2(ReadData2)
    );

    initial clk = 1'b0;
    always #1000 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Edge, then let inputs change well clear of it.
    task automatic edge_step();
        @(posedge clk);
        #100;
    endtask

    function automatic logic [63:0] xval(input int i);
        return base + 64'(i);
    endfunction

    initial begin
        reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        ReadRegister1 = '0; ReadRegister2 = '0;
        #300;
        ReadRegister1 = 5'd31;
        #800;
        check("xzr_before_reset", ReadData1, 64'h0);
        edge_step();
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            #750;
            check($sformatf("reset_rd1_x%0d", i), ReadData1, 64'h0);
            check($sformatf("reset_rd2_x%0d", 31 - i), ReadData2, 64'h0);
            $display("reset read rd1=X%0d rd2=X%0d", i, 31 - i);
        end

        RegWrite = 1'b1;
        for (int i = 0; i < 31; i++) begin
            WriteRegister = 5'(i);
            WriteData = xval(i);
            edge_step();
            $display("write X%0d = %h", i, xval(i));
        end
        RegWrite = 1'b0;

        for (int i = 0; i <= 30; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(30 - i);
            #750;
            check($sformatf("pair_rd1_x%0d", i), ReadData1, xval(i));
            check($sformatf("pair_rd2_x%0d", 30 - i), ReadData2, xval(30 - i));
            $display("pair read X%0d X%0d", i, 30 - i);
        end
        ReadRegister1 = 5'd31;
        ReadRegister2 = 5'd31;
        #750;
        check("x31_rd1", ReadData1, 64'h0);
        check("x31_rd2", ReadData2, 64'h0);

        RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = '1;
        edge_step();
        RegWrite = 1'b0;
        #750;
        check("xzr_write_rd1", ReadData1, 64'h0);
        check("xzr_write_rd2", ReadData2, 64'h0);
        for (int i = 0; i < 31; i++) begin
            ReadRegister1 = 5'(i);
            #750;
            check($sformatf("xzr_write_keep_x%0d", i), ReadData1, xval(i));
        end
        $display("write X31 all-ones ignored");

        RegWrite = 1'b0; WriteRegister = 5'd5; WriteData = 64'hDEAD_BEEF;
        edge_step();
        ReadRegister1 = 5'd5;
        #750;
        check("regwrite_low_x5", ReadData1, xval(5));
        $display("regwrite=0 to X5 ignored");

        RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'd1;
        edge_step();
        WriteData = 64'd2;
        ReadRegister1 = 5'd7;
        ReadRegister2 = 5'd7;
        #750;
        check("x7_old_rd1", ReadData1, 64'd1);
        check("x7_old_rd2", ReadData2, 64'd1);
        @(posedge clk);
        #750;
        RegWrite = 1'b0;
        check("x7_new_rd1", ReadData1, 64'd2);
        check("x7_new_rd2", ReadData2, 64'd2);
        $display("same-cycle read/write X7 1->2");

        RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 64'hFF; reset = 1'b1;
        edge_step();
        reset = 1'b0; RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(i);
            #750;
            check($sformatf("rst_prio_rd1_x%0d", i), ReadData1, 64'h0);
            check($sformatf("rst_prio_rd2_x%0d", i), ReadData2, 64'h0);
        end
        $display("reset with write to X3 clears all");

        RegWrite = 1'b1; WriteRegister = 5'd0; WriteData = 64'h55;
        edge_step();
        RegWrite = 1'b0;
        ReadRegister1 = 5'd0;
        #750;
        check("x0_after_rewrite", ReadData1, 64'h55);
        ReadRegister1 = 5'd31;
        #750;
        check("rr1_0_to_31", ReadData1, 64'h0);
        $display("rr1 change 0->31");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
